vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, 640, visible pixels per line.
REQ-002 SHALL have parameter H_FP, 16, horizontal front porch in pixels.
REQ-003 SHALL have parameter H_SYNC, 96, hsync width in pixels.
REQ-004 SHALL have parameter H_BP, 48, horizontal back porch in pixels.
REQ-005 SHALL have parameter V_ACTIVE, 480, visible lines per frame.
REQ-006 SHALL have parameter V_FP, 10, vertical front porch in lines.
REQ-007 SHALL have parameter V_SYNC, 2, vsync width in lines.
REQ-008 SHALL have parameter V_BP, 29, vertical back porch in lines.
REQ-009 SHALL have parameter HSYNC_POL, 0, asserted level of hsync.
REQ-010 SHALL have parameter VSYNC_POL, 0, asserted level of vsync.
REQ-011 SHALL have parameter CNT_W, 10, width of all position counters.
REQ-012 SHALL have parameter FRAME_W, 8, width of the frame counter.
REQ-013 SHALL have port clk, input, 1, single clock for all logic.
REQ-014 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-015 SHALL have port pix_en, input, 1, pixel tick; state advances only on clk edges with pix_en=1.
REQ-016 SHALL have ports hcnt and vcnt, output, CNT_W each, raw horizontal and vertical position.
REQ-017 SHALL have ports x and y, output, CNT_W each, active-area coordinates.
REQ-018 SHALL have ports hsync, vsync and de, output, 1 each, sync outputs and display enable.
REQ-019 SHALL have ports line_start, frame_start and vblank_start, output, 1 each, event pulses.
REQ-020 SHALL have port frame_cnt, output, FRAME_W, frame counter.

Function
REQ-021 SHALL define H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL likewise; the defaults give 800x521.
REQ-022 SHALL order regions as active, front porch, sync, back porch, starting at count 0.
REQ-023 SHALL, on each pix_en clk edge, set hcnt to hcnt+1, or to 0 when hcnt=H_TOTAL-1.
REQ-024 SHALL advance vcnt only when hcnt wraps: vcnt+1, or 0 when vcnt=V_TOTAL-1.
REQ-025 SHALL hold every output and internal register unchanged on clk edges with pix_en=0, except the pulses.
REQ-026 SHALL register all outputs and decode them from the next-state counters, so hsync, vsync, de, x and y describe the same (hcnt,vcnt) presented in that cycle with zero skew.
REQ-027 SHALL drive hsync=HSYNC_POL exactly when hcnt is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], else ~HSYNC_POL; vsync likewise with the V_* parameters.
REQ-028 SHALL drive de=1 exactly when hcnt<H_ACTIVE and vcnt<V_ACTIVE.
REQ-029 SHALL drive x=hcnt and y=vcnt while de=1, and x=0 and y=0 while de=0.
REQ-030 SHALL pulse line_start high for exactly one clk on the edge where hcnt becomes 0.
REQ-031 SHALL pulse frame_start for one clk when (hcnt,vcnt) becomes (0,0).
REQ-032 SHALL pulse vblank_start for one clk when (hcnt,vcnt) becomes (0,V_ACTIVE).
REQ-033 SHALL clear every pulse on the next clk edge regardless of pix_en, so a pulse never exceeds one clk.
REQ-034 SHALL increment frame_cnt modulo 2^FRAME_W in the same edge that raises frame_start.
REQ-035 SHALL require CNT_W to hold V_TOTAL-1 and H_TOTAL-1, and H_SYNC, V_SYNC, H_BP and V_BP to each be >=1; the behaviour is undefined otherwise.

Reset
REQ-036 SHALL, while rst=0, asynchronously force hcnt=H_TOTAL-1, vcnt=V_TOTAL-1, frame_cnt all-ones, de=0, x=0, y=0, all pulses 0, hsync=~HSYNC_POL and vsync=~VSYNC_POL.
REQ-037 SHALL, on the first pix_en edge after release, move to (0,0) with frame_start=1, line_start=1, frame_cnt=0 and de=1.
REQ-038 SHALL return outputs to the REQ-036 values within the same cycle when rst is asserted mid-frame, with no pulse emitted.

Verification
REQ-039 Reset, then pix_en=1 steady, defaults -> first edge gives hcnt=0, vcnt=0, de=1, frame_start=1, frame_cnt=0; hsync low for hcnt 656..751 only; line period 800 clk.
REQ-040 Run one full frame -> vsync low for vcnt 490..491 only; vblank_start at (0,480); next frame_start exactly 416800 clk after the first; frame_cnt=1.
REQ-041 pix_en toggled 1/0 each clk -> counters advance every other clk; all pulses one clk wide; frame period 833600 clk.
REQ-042 Parameters 8/2/2/2 horizontal, 4/1/1/1 vertical, both polarities 1, FRAME_W=2 -> hsync high for hcnt 10..11, x=0 outside de, frame_cnt wraps 3->0 on the fifth frame_start.
REQ-043 Assert rst at (300,200) while de=1 -> hcnt=799, vcnt=520 and de=0 immediately; after release, one pix_en edge gives (0,0) with frame_start.

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: pixel-tick driven VGA raster counters with registered, zero-skew sync/enable decode and event pulses.
module vga_timing_gen #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 29,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int CNT_W     = 10,
    parameter int FRAME_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pix_en,
    output logic [CNT_W-1:0]   hcnt,
    output logic [CNT_W-1:0]   vcnt,
    output logic [CNT_W-1:0]   x,
    output logic [CNT_W-1:0]   y,
    output logic               hsync,
    output logic               vsync,
    output logic               de,
    output logic               line_start,
    output logic               frame_start,
    output logic               vblank_start,
    output logic [FRAME_W-1:0] frame_cnt
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT   = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT   = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEG  = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END  = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEG  = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END  = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [CNT_W-1:0]   h_q, h_d, v_q, v_d, x_q, x_d, y_q, y_d;
    logic [FRAME_W-1:0] fc_q, fc_d;
    logic               hs_q, hs_d, vs_q, vs_d, de_q, de_d;
    logic               ls_q, ls_d, fs_q, fs_d, vb_q, vb_d;
    logic               h_wrap;

    // Outputs are decoded from the next-state counters so they line up with hcnt/vcnt.
    always_comb begin
        h_wrap = h_q == H_LAST;
        h_d    = h_q;
        v_d    = v_q;
        if (pix_en) begin
            h_d = h_wrap ? '0 : h_q + 1'b1;
            if (h_wrap) v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
        end
        hs_d = (h_d >= HS_BEG && h_d < HS_END) ? HSYNC_POL : ~HSYNC_POL;
        vs_d = (v_d >= VS_BEG && v_d < VS_END) ? VSYNC_POL : ~VSYNC_POL;
        de_d = h_d < H_ACT && v_d < V_ACT;
        x_d  = de_d ? h_d : '0;
        y_d  = de_d ? v_d : '0;
        ls_d = pix_en && h_d == '0;
        fs_d = ls_d && v_d == '0;
        vb_d = ls_d && v_d == V_ACT;
        fc_d = fs_d ? fc_q + 1'b1 : fc_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_q  <= H_LAST;
            v_q  <= V_LAST;
            fc_q <= '1;
            x_q  <= '0;
            y_q  <= '0;
            hs_q <= ~HSYNC_POL;
            vs_q <= ~VSYNC_POL;
            de_q <= 1'b0;
            ls_q <= 1'b0;
            fs_q <= 1'b0;
            vb_q <= 1'b0;
        end else begin
            h_q  <= h_d;
            v_q  <= v_d;
            fc_q <= fc_d;
            x_q  <= x_d;
            y_q  <= y_d;
            hs_q <= hs_d;
            vs_q <= vs_d;
            de_q <= de_d;
            ls_q <= ls_d;
            fs_q <= fs_d;
            vb_q <= vb_d;
        end
    end

    assign hcnt         = h_q;
    assign vcnt         = v_q;
    assign x            = x_q;
    assign y            = y_q;
    assign hsync        = hs_q;
    assign vsync        = vs_q;
    assign de           = de_q;
    assign line_start   = ls_q;
    assign frame_start  = fs_q;
    assign vblank_start = vb_q;
    assign frame_cnt    = fc_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: randomized pix_en/reset stimulus against a linear pixel-index raster model, scoreboard-checked.
module tb_vga_timing_gen;
    localparam int HA = 8, HF = 2, HS = 2, HB = 2;
    localparam int VA = 4, VF = 1, VS = 1, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;
    localparam int CW = 4, FW = 2;
    localparam bit HP = 1'b1, VP = 1'b1;

    typedef struct packed {
        logic [CW-1:0] h, v, x, y;
        logic hs, vs, de, ls, fs, vb;
        logic [FW-1:0] fc;
    } exp_t;

    logic clk = 1'b0, rst = 1'b0, pix_en = 1'b0;
    logic [CW-1:0] hcnt, vcnt, x, y;
    logic hsync, vsync, de, line_start, frame_start, vblank_start;
    logic [FW-1:0] frame_cnt;

    int errors = 0, checks = 0;
    bit armed = 1'b0;
    exp_t exp_q[$];
    int p, fc;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HSYNC_POL(HP), .VSYNC_POL(VP), .CNT_W(CW), .FRAME_W(FW)
    ) dut (
        .clk(clk), .rst(rst), .pix_en(pix_en),
        .hcnt(hcnt), .vcnt(vcnt), .x(x), .y(y),
        .hsync(hsync), .vsync(vsync), .de(de),
        .line_start(line_start), .frame_start(frame_start), .vblank_start(vblank_start),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    // Expected outputs for linear pixel index pos within the frame.
    function automatic exp_t model(int pos, int frames, bit ticked);
        exp_t e;
        int h, v;
        h = pos % HT;
        v = pos / HT;
        e.h  = CW'(h);
        e.v  = CW'(v);
        e.hs = (h >= HA + HF && h < HA + HF + HS) ? HP : ~HP;
        e.vs = (v >= VA + VF && v < VA + VF + VS) ? VP : ~VP;
        e.de = h < HA && v < VA;
        e.x  = e.de ? CW'(h) : '0;
        e.y  = e.de ? CW'(v) : '0;
        e.ls = ticked && h == 0;
        e.fs = ticked && pos == 0;
        e.vb = ticked && pos == VA * HT;
        e.fc = FW'(frames);
        return e;
    endfunction

    function automatic exp_t observed();
        exp_t g;
        g = '{hcnt, vcnt, x, y, hsync, vsync, de, line_start, frame_start, vblank_start, frame_cnt};
        return g;
    endfunction

    // Called at a negedge: model the effect of the coming posedge and queue it.
    task automatic step(input bit r, input bit en);
        rst    = r;
        pix_en = en;
        if (!r) begin
            p  = FT - 1;
            fc = (1 << FW) - 1;
            exp_q.push_back(model(p, fc, 1'b0));
        end else if (en) begin
            p = (p + 1) % FT;
            if (p == 0) fc = (fc + 1) % (1 << FW);
            exp_q.push_back(model(p, fc, 1'b1));
        end else begin
            exp_q.push_back(model(p, fc, 1'b0));
        end
        armed = 1'b1;
    endtask

    task automatic check_async_reset();
        exp_t g, e;
        rst = 1'b0;
        #1;
        g = observed();
        e = model(FT - 1, (1 << FW) - 1, 1'b0);
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL async_reset got=%h exp=%h", g, e);
        end
    endtask

    initial begin : monitor
        exp_t g, e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                g = observed();
                checks++;
                if (g !== e) begin
                    errors++;
                    $display("FAIL scoreboard t=%0t got=%h exp=%h", $time, g, e);
                end
            end else if (armed) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_empty t=%0t got=%h exp=none", $time, observed());
            end
        end
    end

    initial begin : stimulus
        p  = FT - 1;
        fc = (1 << FW) - 1;
        @(negedge clk);
        #1;
        checks++;
        if (observed() !== model(FT - 1, (1 << FW) - 1, 1'b0)) begin
            errors++;
            $display("FAIL reset_state got=%h exp=%h", observed(), model(FT - 1, (1 << FW) - 1, 1'b0));
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            step(1'b0, 1'b0);
        end
        for (int i = 0; i < 5 * FT + 20; i++) begin
            @(negedge clk);
            step(1'b1, 1'b1);
        end
        for (int i = 0; i < 3 * FT; i++) begin
            @(negedge clk);
            step(1'b1, i[0] == 1'b0);
        end
        // Park inside the active area, then reset asynchronously mid-frame.
        while (!(p % HT == 3 && p / HT == 2)) begin
            @(negedge clk);
            step(1'b1, 1'b1);
        end
        @(negedge clk);
        check_async_reset();
        step(1'b0, 1'b1);
        @(negedge clk);
        step(1'b0, 1'b1);
        for (int i = 0; i < 4 * FT; i++) begin
            @(negedge clk);
            step(($urandom_range(0, 199) != 0), ($urandom_range(0, 2) != 0));
        end
        @(negedge clk);
        step(1'b1, 1'b0);
        @(posedge clk);
        #2;
        armed = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain got=%0d exp=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
